// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the snake round/match sequencer.
package game_round_ctrl_pkg;

    typedef enum logic {
        MENU = 1'b0,
        GAME = 1'b1
    } game_mode_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        PLAY       = 3'd2,
        RESULT     = 3'd3,
        MATCH_OVER = 3'd4
    } round_state_e;

    typedef enum logic [2:0] {
        NO_RES = 3'd0,
        WIN    = 3'd1,
        LOSE   = 3'd2,
        DRAW   = 3'd3,
        ERR    = 3'd4
    } round_outcome_e;

    localparam int SCORE_W   = 4;
    localparam int SCORE_MAX = 15;
    localparam int CD_W      = 2;

    // Score increment that sticks at 15 instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_W'(SCORE_MAX)) ? v : v + SCORE_W'(1);
    endfunction

    // Speed step: one eighth of the base period, rounded up to an even count.
    function automatic int speed_step(input int tick);
        int s;
        s = tick / 8;
        if (s % 2 != 0) s = s + 1;
        if (s < 2) s = 2;
        return s;
    endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Datapath/UI bundle of the round sequencer.
// master: the sequencer itself; slave: datapath, renderer and input logic.
interface game_round_ctrl_if;
    import game_round_ctrl_pkg::*;

    logic                 start;
    logic                 won;
    logic                 lost;
    logic                 draw;
    logic                 com_err;
    logic                 eaten;
    game_mode_e           mode;
    logic                 clk_div;
    round_state_e         state;
    round_outcome_e       outcome;
    logic [SCORE_W-1:0]   score1;
    logic [SCORE_W-1:0]   score2;
    logic [CD_W-1:0]      cd_value;

    modport master (
        input  start, won, lost, draw, com_err, eaten,
        output mode, clk_div, state, outcome, score1, score2, cd_value
    );

    modport slave (
        output start, won, lost, draw, com_err, eaten,
        input  mode, clk_div, state, outcome, score1, score2, cd_value
    );

endinterface

// File: rtl/game_round_ctrl_tick_gen.sv
// Programmable even divider producing the snake move tick.
// The period is captured at each period boundary so a new value never
// splits a period; while disabled the counter sits preloaded so the first
// enabled cycle is the start of a fresh period.
module game_round_ctrl_tick_gen #(
    parameter int PW = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [PW-1:0] period_i,
    output logic          clk_div_o,
    output logic          period_end_o
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] per_q;

    // Down-counter with terminal count at 0; reload picks up the current period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            per_q <= '0;
        end else if (!en_i || cnt_q == '0) begin
            cnt_q <= period_i - PW'(1);
            per_q <= period_i;
        end else begin
            cnt_q <= cnt_q - PW'(1);
        end
    end

    assign clk_div_o    = en_i && (cnt_q >= (per_q >> 1));
    assign period_end_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Round/match sequencer for the snake move_n_collisions datapath.
// Optional feature macro: SNAKE_SPEEDUP_EN (tick period shrinks as points are eaten).
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | menu, waiting for start
// COUNTDOWN  | snakes frozen, cd_value counts down once per tick period
// PLAY       | move tick running, first datapath event ends the round
// RESULT     | round outcome shown for RESULT_CYCLES
// MATCH_OVER | a player reached WINS_TO_MATCH, start returns to IDLE
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int TICK_CYCLES     = 6_500_000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int RESULT_CYCLES   = 130_000_000,
    parameter int WINS_TO_MATCH   = 3,
    parameter int MIN_TICK_CYCLES = 1_625_000,
    parameter int SPEEDUP_POINTS  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    game_round_ctrl_if.master ctrl_io
);

    localparam int PW = $clog2(TICK_CYCLES) + 1;
    localparam int RW = $clog2(RESULT_CYCLES) + 1;
    localparam logic [PW-1:0]      TICK_P   = PW'(TICK_CYCLES);
    localparam logic [RW-1:0]      RES_LAST = RW'(RESULT_CYCLES - 1);
    localparam logic [CD_W-1:0]    CD_INIT  = CD_W'(COUNTDOWN_TICKS);
    localparam logic [SCORE_W-1:0] WINS     = SCORE_W'(WINS_TO_MATCH);

    round_state_e       state_q, state_d;
    round_outcome_e     outcome_q, outcome_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic [RW-1:0]      res_cnt_q, res_cnt_d;

    logic          tick_en;
    logic          tick_div;
    logic          period_end;
    logic [PW-1:0] period;

    assign tick_en = (state_q == COUNTDOWN) || (state_q == PLAY);

`ifdef SNAKE_SPEEDUP_EN
    localparam int PTW = $clog2(SPEEDUP_POINTS) + 1;
    localparam logic [PW-1:0] STEP_P = PW'(speed_step(TICK_CYCLES));
    localparam logic [PW-1:0] MIN_P  = PW'(MIN_TICK_CYCLES);

    logic           eaten_q;
    logic [PTW-1:0] pts_q, pts_d;
    logic [PW-1:0]  period_q, period_d;

    // Point counting and period shrink; held at base values outside COUNTDOWN/PLAY
    // so the tick generator is already preloaded with TICK_CYCLES on round entry.
    always_comb begin
        pts_d    = pts_q;
        period_d = period_q;
        if (!tick_en) begin
            pts_d    = '0;
            period_d = TICK_P;
        end else if (state_q == PLAY && ctrl_io.eaten && !eaten_q) begin
            if (pts_q == PTW'(SPEEDUP_POINTS - 1)) begin
                pts_d    = '0;
                period_d = (period_q >= MIN_P + STEP_P) ? period_q - STEP_P : MIN_P;
            end else begin
                pts_d = pts_q + PTW'(1);
            end
        end
    end

    // Speed-up registers and eaten edge detector.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            eaten_q  <= 1'b0;
            pts_q    <= '0;
            period_q <= TICK_P;
        end else begin
            eaten_q  <= ctrl_io.eaten;
            pts_q    <= pts_d;
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ctrl_io.eaten, (MIN_TICK_CYCLES != 0), (SPEEDUP_POINTS != 0)};
    assign period     = TICK_P;
`endif

    game_round_ctrl_tick_gen #(
        .PW (PW)
    ) u_tick_gen (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .en_i         (tick_en),
        .period_i     (period),
        .clk_div_o    (tick_div),
        .period_end_o (period_end)
    );

    // Round FSM next-state, outcome latch and score update.
    always_comb begin
        state_d   = state_q;
        outcome_d = outcome_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        cd_d      = cd_q;
        res_cnt_d = res_cnt_q;
        case (state_q)
            IDLE: begin
                if (ctrl_io.start) begin
                    state_d = COUNTDOWN;
                    cd_d    = CD_INIT;
                end
            end
            COUNTDOWN: begin
                if (period_end) begin
                    cd_d = cd_q - CD_W'(1);
                    if (cd_q == CD_W'(1)) state_d = PLAY;
                end
            end
            PLAY: begin
                if (ctrl_io.com_err || ctrl_io.draw || ctrl_io.won || ctrl_io.lost) begin
                    state_d   = RESULT;
                    res_cnt_d = RES_LAST;
                    if (ctrl_io.com_err) begin
                        outcome_d = ERR;
                    end else if (ctrl_io.draw || (ctrl_io.won && ctrl_io.lost)) begin
                        outcome_d = DRAW;
                    end else if (ctrl_io.won) begin
                        outcome_d = WIN;
                        score1_d  = sat_inc(score1_q);
                    end else begin
                        outcome_d = LOSE;
                        score2_d  = sat_inc(score2_q);
                    end
                end
            end
            RESULT: begin
                if (res_cnt_q == '0) begin
                    if (score1_q == WINS || score2_q == WINS) begin
                        state_d = MATCH_OVER;
                    end else begin
                        state_d = COUNTDOWN;
                        cd_d    = CD_INIT;
                    end
                end else begin
                    res_cnt_d = res_cnt_q - RW'(1);
                end
            end
            MATCH_OVER: begin
                if (ctrl_io.start) begin
                    state_d  = IDLE;
                    score1_d = '0;
                    score2_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and round bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            outcome_q <= NO_RES;
            score1_q  <= '0;
            score2_q  <= '0;
            cd_q      <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            outcome_q <= outcome_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            cd_q      <= cd_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    assign ctrl_io.mode     = tick_en ? GAME : MENU;
    assign ctrl_io.clk_div  = tick_div && (state_q == PLAY);
    assign ctrl_io.state    = state_q;
    assign ctrl_io.outcome  = outcome_q;
    assign ctrl_io.score1   = score1_q;
    assign ctrl_io.score2   = score2_q;
    assign ctrl_io.cd_value = cd_q;

endmodule
